// File: rtl/conv_pkg.sv
// Shared parameter defaults and FSM encoding for the convolution datapath
// (conv_weight_feeder and ConvChannel).
package conv_pkg;

    localparam int unsigned CONV_DATA_WIDTH   = 32;
    localparam int unsigned CONV_KERNEL_SIZE  = 9;
    localparam int unsigned CONV_INPUT_DIM    = 4;
    localparam int unsigned CONV_ADDR_WIDTH   = 8;
    localparam int unsigned CONV_DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // Counter width for n states; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_weight_cache.sv
// One-burst weight cache: KernelSize beats plus a base-address tag and valid
// flag. Only instantiated when CONV_WEIGHT_CACHE_EN is defined.
module conv_weight_cache
    import conv_pkg::*;
#(
    parameter int unsigned DataWidth  = CONV_DATA_WIDTH,
    parameter int unsigned KernelSize = CONV_KERNEL_SIZE,
    parameter int unsigned InputDim   = CONV_INPUT_DIM,
    parameter int unsigned AddrWidth  = CONV_ADDR_WIDTH,
    parameter int unsigned IdxWidth   = cnt_width(KernelSize)
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          wr_en,
    input  logic [IdxWidth-1:0]           wr_idx,
    input  logic [InputDim*DataWidth-1:0] wr_data,
    input  logic [IdxWidth-1:0]           rd_idx,
    output logic [InputDim*DataWidth-1:0] rd_data,
    input  logic                          tag_load,
    input  logic [AddrWidth-1:0]          tag_in,
    input  logic                          invalidate,
    input  logic                          commit,
    output logic                          valid,
    output logic [AddrWidth-1:0]          tag
);

    logic [InputDim*DataWidth-1:0] beat_q [KernelSize];
    logic                          valid_q, valid_d;
    logic [AddrWidth-1:0]          tag_q, tag_d;

    // Invalidation outranks commit so a flush in the DONE cycle wins.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (tag_load) begin
            tag_d = tag_in;
        end
        if (invalidate) begin
            valid_d = 1'b0;
        end else if (commit) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    // Beat storage has no reset; valid_q alone decides whether it is trusted.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            beat_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = beat_q[rd_idx];
    assign valid   = valid_q;
    assign tag     = tag_q;

endmodule

// File: rtl/conv_weight_feeder.sv
// Weight burst fetcher feeding ConvChannel: KernelSize memory reads per start.
// Optional replay cache enabled by defining CONV_WEIGHT_CACHE_EN.
module conv_weight_feeder
    import conv_pkg::*;
#(
    parameter int unsigned DataWidth  = CONV_DATA_WIDTH,
    parameter int unsigned KernelSize = CONV_KERNEL_SIZE,
    parameter int unsigned InputDim   = CONV_INPUT_DIM,
    parameter int unsigned AddrWidth  = CONV_ADDR_WIDTH
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          start,
    input  logic [AddrWidth-1:0]          base_addr,
    input  logic                          cache_flush,
    output logic                          mem_rd_en,
    output logic [AddrWidth-1:0]          mem_addr,
    input  logic [InputDim*DataWidth-1:0] mem_rd_data,
    output logic [InputDim*DataWidth-1:0] weight_out,
    output logic                          weight_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned         BeatWidth = InputDim * DataWidth;
    localparam int unsigned         CntWidth  = cnt_width(KernelSize);
    localparam logic [CntWidth-1:0] LastBeat  = CntWidth'(KernelSize - 1);
    localparam logic [CntWidth-1:0] LastDrain = CntWidth'(CONV_DRAIN_CYCLES - 1);

    feeder_state_e        state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 issue_q, issue_d;
    logic                 hit_q, hit_d;
    logic                 pend_q, pend_d;
    logic [CntWidth-1:0]  pend_idx_q, pend_idx_d;
    logic                 rd_en_q, rd_en_d;
    logic [BeatWidth-1:0] wout_q, wout_d;
    logic                 wvalid_q, wvalid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_ok;
    logic                 cache_hit;
    logic [BeatWidth-1:0] beat_src;

    assign start_ok = (state_q == ST_IDLE) && start;

    // issue_q marks a beat fetched this cycle (from memory or cache); its data
    // lands a cycle later (pend_q) and is registered onto weight_out after that.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        issue_d    = 1'b0;
        hit_d      = hit_q;
        pend_d     = issue_q;
        pend_idx_d = cnt_q;
        wvalid_d   = pend_q;
        wout_d     = pend_q ? beat_src : '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    addr_d  = base_addr;
                    issue_d = 1'b1;
                    hit_d   = cache_hit;
                end
            end
            ST_READ: begin
                if (cnt_q == LastBeat) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CntWidth'(1);
                    addr_d  = addr_q + AddrWidth'(1);
                    issue_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LastDrain) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        rd_en_d = issue_d & ~hit_d;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            issue_q    <= 1'b0;
            hit_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rd_en_q    <= 1'b0;
            wout_q     <= '0;
            wvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            hit_q      <= hit_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rd_en_q    <= rd_en_d;
            wout_q     <= wout_d;
            wvalid_q   <= wvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef CONV_WEIGHT_CACHE_EN
    logic                 flushed_q, flushed_d;
    logic                 cache_valid;
    logic [AddrWidth-1:0] cache_tag;
    logic [BeatWidth-1:0] cache_rd;

    assign cache_hit = cache_valid && (cache_tag == base_addr) && !cache_flush;
    assign beat_src  = hit_q ? cache_rd : mem_rd_data;
    // Any flush seen between start and DONE keeps this burst out of the cache.
    assign flushed_d = (state_q == ST_IDLE) ? cache_flush : (flushed_q | cache_flush);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            flushed_q <= 1'b0;
        end else begin
            flushed_q <= flushed_d;
        end
    end

    conv_weight_cache #(
        .DataWidth  (DataWidth),
        .KernelSize (KernelSize),
        .InputDim   (InputDim),
        .AddrWidth  (AddrWidth),
        .IdxWidth   (CntWidth)
    ) u_cache (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .wr_en      (pend_q & ~hit_q),
        .wr_idx     (pend_idx_q),
        .wr_data    (mem_rd_data),
        .rd_idx     (pend_idx_q),
        .rd_data    (cache_rd),
        .tag_load   (start_ok & ~cache_hit),
        .tag_in     (base_addr),
        .invalidate (cache_flush | (start_ok & ~cache_hit)),
        .commit     ((state_q == ST_DONE) & ~flushed_q),
        .valid      (cache_valid),
        .tag        (cache_tag)
    );
`else
    logic unused_cfg;

    assign cache_hit  = 1'b0;
    assign beat_src   = mem_rd_data;
    assign unused_cfg = cache_flush ^ start_ok ^ (^pend_idx_q);
`endif

    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign weight_out   = wout_q;
    assign weight_valid = wvalid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv_weight_feeder.sv
// Randomised bench for conv_weight_feeder against a burst-level timing model;
// cache behaviour is modelled when CONV_WEIGHT_CACHE_EN is defined.
module tb_conv_weight_feeder;

    localparam int K  = 9;
    localparam int DW = 32;
    localparam int ID = 4;
    localparam int AW = 8;
    localparam int BW = ID * DW;
`ifdef CONV_WEIGHT_CACHE_EN
    localparam int ReplayRd = 0;
`else
    localparam int ReplayRd = K;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n, start, cache_flush;
    logic [AW-1:0] base_addr, mem_addr;
    logic          mem_rd_en, weight_valid, busy, done;
    logic [BW-1:0] mem_rd_data, weight_out;

    conv_weight_feeder #(
        .DataWidth  (DW),
        .KernelSize (K),
        .InputDim   (ID),
        .AddrWidth  (AW)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .cache_flush  (cache_flush),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .weight_out   (weight_out),
        .weight_valid (weight_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [BW-1:0] mem [256];

    // Burst model: one accepted start at cycle s0 defines every output by offset.
    bit            active = 0;
    int            s0 = 0;
    logic [AW-1:0] b_base = '0;
    bit            b_hit = 0;
    bit            b_flushed = 0;
    logic [BW-1:0] b_data [K];
    bit            c_valid = 0;
    logic [AW-1:0] c_base = '0;
    logic [BW-1:0] c_data [K];

    logic [AW-1:0] obs_addr [$];
    int            obs_rd_cyc [$];
    logic [BW-1:0] obs_beat [$];
    int            obs_wv_cyc [$];
    int            obs_done_cyc [$];

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : rand_beat();

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bit model_idle();
        return !active || (cyc - s0 >= K + 4);
    endfunction

    task automatic try_start(input logic [AW-1:0] b);
        if (Rst_n === 1'b1 && model_idle()) begin
            active    = 1;
            s0        = cyc;
            b_base    = b;
            b_flushed = 0;
            b_hit     = 0;
`ifdef CONV_WEIGHT_CACHE_EN
            b_hit = c_valid && (c_base == b);
            if (!b_hit) c_valid = 0;
`endif
            for (int i = 0; i < K; i++) b_data[i] = b_hit ? c_data[i] : mem[AW'(int'(b) + i)];
        end
    endtask

    task automatic model_flush();
`ifdef CONV_WEIGHT_CACHE_EN
        c_valid = 0;
        if (!model_idle()) b_flushed = 1;
`endif
    endtask

    task automatic model_reset();
        active  = 0;
        c_valid = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        try_start(b);
        step();
        start     = 1'b0;
        base_addr = AW'($urandom());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !model_idle(); i++) step();
        step();
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_rd_cyc.delete();
        obs_beat.delete();
        obs_wv_cyc.delete();
        obs_done_cyc.delete();
    endtask

    always @(negedge Clk) begin : cmp
        int            k;
        bit            e_rd, e_wv, e_busy, e_done;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_wo;
        e_rd = 0; e_wv = 0; e_busy = 0; e_done = 0; e_addr = '0; e_wo = '0;
        k = cyc - s0;
        if (Rst_n === 1'b1 && active && k >= 1 && k <= K + 3) begin
            e_busy = 1;
            e_done = (k == K + 3);
            if (k <= K) begin
                e_rd   = !b_hit;
                e_addr = AW'(int'(b_base) + k - 1);
            end
            if (k >= 3 && k <= K + 2) begin
                e_wv = 1;
                e_wo = b_data[k-3];
            end
        end
        chk("mem_rd_en", mem_rd_en, e_rd);
        if (e_rd || Rst_n !== 1'b1) chk("mem_addr", mem_addr, e_addr);
        chk("weight_valid", weight_valid, e_wv);
        chk("weight_out", weight_out, e_wo);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (mem_rd_en === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_rd_cyc.push_back(cyc);
        end
        if (weight_valid === 1'b1) begin
            obs_beat.push_back(weight_out);
            obs_wv_cyc.push_back(cyc);
        end
        if (done === 1'b1) obs_done_cyc.push_back(cyc);
`ifdef CONV_WEIGHT_CACHE_EN
        if (e_done && !b_flushed) begin
            c_valid = 1;
            c_base  = b_base;
            for (int i = 0; i < K; i++) c_data[i] = b_data[i];
        end
`endif
    end

    initial begin : main
        int            S, S2, r;
        logic [AW-1:0] b;
        logic [AW-1:0] exp38 [K];
        logic [BW-1:0] first_beats [$];
        exp38 = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        Rst_n = 1'b0; start = 1'b0; base_addr = '0; cache_flush = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = rand_beat();
        repeat (3) step();

        // Start in the very first cycle after reset release, base 0x10.
        Rst_n = 1'b1;
        clear_obs();
        S = cyc;
        drive_start(8'h10);
        wait_idle();
        chk("r37_rd_count", obs_addr.size(), K);
        for (int i = 0; i < obs_addr.size() && i < K; i++) chk("r37_addr", obs_addr[i], 8'h10 + i);
        chk("r37_rd_first", qi(obs_rd_cyc, 0), S + 1);
        chk("r37_rd_last", qi(obs_rd_cyc, K - 1), S + 9);
        chk("r37_wv_first", qi(obs_wv_cyc, 0), S + 3);
        chk("r37_wv_last", qi(obs_wv_cyc, K - 1), S + 11);
        chk("r37_wv_count", obs_beat.size(), K);
        for (int i = 0; i < obs_beat.size() && i < K; i++) chk("r37_beat", obs_beat[i], mem[8'h10 + i]);
        chk("r37_done_count", obs_done_cyc.size(), 1);
        chk("r37_done_cycle", qi(obs_done_cyc, 0), S + 12);

        // Address wrap.
        clear_obs();
        drive_start(8'hFC);
        wait_idle();
        chk("r38_rd_count", obs_addr.size(), K);
        for (int i = 0; i < obs_addr.size() && i < K; i++) begin
            chk("r38_addr", obs_addr[i], exp38[i]);
            chk("r38_beat", obs_beat[i], mem[exp38[i]]);
        end

        // Starts during READ and DONE are ignored.
        clear_obs();
        S = cyc;
        b = 8'h55;
        drive_start(b);
        repeat (3) step();
        drive_start(8'hA0);
        repeat (7) step();
        drive_start(8'hB0);
        wait_idle();
        chk("r39_rd_count", obs_addr.size(), K);
        chk("r39_addr_first", obs_addr[0], b);
        chk("r39_addr_last", obs_addr[K-1], 8'h5D);
        chk("r39_wv_count", obs_beat.size(), K);
        chk("r39_done_count", obs_done_cyc.size(), 1);
        chk("r39_done_cycle", qi(obs_done_cyc, 0), S + 12);

        // Bit-exact pass-through of sign-looking patterns.
        mem[8'h40] = 128'hFFFFFFFF_00000002_FFFFFFFE_00000001;
        clear_obs();
        drive_start(8'h40);
        wait_idle();
        chk("r41_pattern", obs_beat[0], 128'hFFFFFFFF_00000002_FFFFFFFE_00000001);

        // Reset in cycle 6 of a burst, then a clean burst straight after release.
        clear_obs();
        S = cyc;
        drive_start(8'h80);
        repeat (5) step();
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("r40_busy_now", busy, 0);
        chk("r40_rd_en_now", mem_rd_en, 0);
        chk("r40_addr_now", mem_addr, 0);
        chk("r40_wv_now", weight_valid, 0);
        chk("r40_wout_now", weight_out, 0);
        chk("r40_done_now", done, 0);
        step();
        step();
        Rst_n = 1'b1;
        S2 = cyc;
        drive_start(8'h81);
        wait_idle();
        chk("r40_rd_total", obs_addr.size(), 5 + K);
        chk("r40_wv_total", obs_beat.size(), 3 + K);
        chk("r40_done_count", obs_done_cyc.size(), 1);
        chk("r40_done_cycle", qi(obs_done_cyc, 0), S2 + 12);

        // Repeat start at one base: replay from cache only when it is compiled in.
        cache_flush = 1'b1; model_flush(); step(); cache_flush = 1'b0;
        clear_obs();
        drive_start(8'h20);
        wait_idle();
        chk("r42_first_rd", obs_addr.size(), K);
        first_beats = obs_beat;
        for (int i = 0; i < K; i++) mem[8'h20 + i] = rand_beat();
        clear_obs();
        drive_start(8'h20);
        wait_idle();
        chk("r42_second_rd", obs_addr.size(), ReplayRd);
        chk("r42_second_wv", obs_beat.size(), K);
        for (int i = 0; i < obs_beat.size() && i < K; i++)
            chk("r42_second_beat", obs_beat[i], (ReplayRd == 0) ? first_beats[i] : mem[8'h20 + i]);
        cache_flush = 1'b1; model_flush(); step(); cache_flush = 1'b0;
        clear_obs();
        drive_start(8'h20);
        wait_idle();
        chk("r42_third_rd", obs_addr.size(), K);
        for (int i = 0; i < obs_beat.size() && i < K; i++) chk("r42_third_beat", obs_beat[i], mem[8'h20 + i]);

        // Random mix of starts, flushes, resets and memory updates.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                Rst_n = 1'b0;
                model_reset();
                step();
                Rst_n = 1'b1;
            end else if (r < 8) begin
                cache_flush = 1'b1;
                model_flush();
                step();
                cache_flush = 1'b0;
            end else if (r < 40) begin
                b = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'(8'h20 + $urandom_range(0, 2));
                drive_start(b);
            end else begin
                if (r < 55 && model_idle()) mem[$urandom_range(0, 255)] = rand_beat();
                step();
            end
        end
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
